// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned, so the low two address bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} pairs; flush discards everything not yet popped.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  fetch_entry_t     mem_r [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  // Guard the handshakes so a misbehaving caller can never over/underflow.
  always_comb begin
    full      = (count_r == CNT_W'(DEPTH));
    empty     = (count_r == CNT_W'(0));
    pop_ok_s  = pop & ~empty;
    push_ok_s = push & (~full | pop_ok_s);
    head      = mem_r[rd_ptr_r];
  end

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      count_r  <= '0;
      rd_ptr_r <= wr_ptr_r;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches one word per cycle into the
// fetch queue, and redirects/flushes on requests from execute.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_ren,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  logic [31:0]  pc_r;
  logic         pop_s;
  logic         fetch_s;
  logic         full_s;
  logic         empty_s;
  fetch_entry_t head_s;
  fetch_entry_t wr_entry_s;

  // A full queue can still take a new entry in the cycle decode drains its head.
  always_comb begin
    pop_s            = out_valid & out_ready;
    fetch_s          = (~full_s | pop_s) & ~redirect_valid & ~rst;
    wr_entry_s.pc    = pc_r;
    wr_entry_s.instr = imem_rdata;
  end

  assign imem_addr = pc_r;
  assign imem_ren  = fetch_s;
  assign out_valid = ~empty_s;
  assign out_pc    = head_s.pc;
  assign out_instr = head_s.instr;

  // Program counter: redirect wins over sequential advance; stalls hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      pc_r <= align_pc(redirect_pc);
    end else if (fetch_s) begin
      pc_r <= pc_r + 32'd4;
    end else begin
      pc_r <= pc_r;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk     (clk),
    .rst     (rst),
    .push    (fetch_s),
    .pop     (pop_s),
    .flush   (redirect_valid),
    .wr_data (wr_entry_s),
    .head    (head_s),
    .full    (full_s),
    .empty   (empty_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, async reset sequence,
// then randomized traffic against a queue-based reference model.
module tb_fetch_unit;

  localparam int DEPTH = 2;
  localparam int NV    = 27;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_ren;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  logic [31:0] imem_addr2;
  logic        imem_ren2;
  logic [31:0] imem_rdata2;
  logic        out_valid2;
  logic [31:0] out_pc2;
  logic [31:0] out_instr2;

  int n_pass  = 0;
  int n_total = 0;
  int cur     = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_rdata  = mem_word(imem_addr);
  assign imem_rdata2 = mem_word(imem_addr2);

  fetch_unit #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_ren(imem_ren),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready)
  );

  fetch_unit #(.RESET_PC(32'h0000_0200), .FQ_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_ren(imem_ren2),
    .imem_rdata(imem_rdata2), .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
    .out_valid(out_valid2), .out_pc(out_pc2), .out_instr(out_instr2), .out_ready(1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic        eren;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic [31:0] ei, input logic eren, input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev;
    v.epc = epc; v.einstr = ei; v.eren = eren; v.eaddr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s (step %0d): got %h, expected %h", name, cur, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    #1;
  endtask

  // Reference model state: architectural PC and an ordered list of pending fetches.
  logic [31:0] m_pc;
  logic [63:0] mq[$];

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;

    // Free run after reset.
    tbl[0]  = mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0);
    tbl[1]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0);
    tbl[2]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0,         32'h1000_0000, 1'b1, 32'h4);
    tbl[3]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4,         32'h1000_0001, 1'b1, 32'h8);
    tbl[4]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8,         32'h1000_0002, 1'b1, 32'hC);
    // Backpressure: fill, stall, then full-with-pop streaming.
    tbl[5]  = mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0);
    tbl[6]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0);
    tbl[7]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,         32'h1000_0000, 1'b1, 32'h4);
    tbl[8]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,         32'h1000_0000, 1'b0, 32'h8);
    tbl[9]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,         32'h1000_0000, 1'b0, 32'h8);
    tbl[10] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,         32'h1000_0000, 1'b0, 32'h8);
    tbl[11] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0,         32'h1000_0000, 1'b1, 32'h8);
    tbl[12] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4,         32'h1000_0001, 1'b1, 32'hC);
    tbl[13] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8,         32'h1000_0002, 1'b1, 32'h10);
    // Redirect with two entries queued.
    tbl[14] = mk(1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b1, 32'hC, 32'h1000_0003, 1'b0, 32'h14);
    tbl[15] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 32'h100);
    tbl[16] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100,       32'h1000_0040, 1'b1, 32'h104);
    tbl[17] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h104,       32'h1000_0041, 1'b1, 32'h108);
    // Redirect while full and stalled, with a same-cycle pop.
    tbl[18] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h108,       32'h1000_0042, 1'b1, 32'h10C);
    tbl[19] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h108,       32'h1000_0042, 1'b0, 32'h110);
    tbl[20] = mk(1'b0, 1'b1, 32'h0000_0206, 1'b1, 1'b1, 32'h108, 32'h1000_0042, 1'b0, 32'h110);
    tbl[21] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 32'h204);
    tbl[22] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h204,       32'h1000_0081, 1'b1, 32'h208);
    // PC wrap-around at the top of the address space.
    tbl[23] = mk(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h208, 32'h1000_0082, 1'b0, 32'h20C);
    tbl[24] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         32'h0,         1'b1, 32'hFFFF_FFFC);
    tbl[25] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h4FFF_FFFF, 1'b1, 32'h0);
    tbl[26] = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0,         32'h1000_0000, 1'b1, 32'h4);

    #1;
    for (int i = 0; i < NV; i++) begin
      cur = i;
      apply(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk("t_out_valid", {31'h0, out_valid}, {31'h0, tbl[i].ev});
      chk("t_imem_ren", {31'h0, imem_ren}, {31'h0, tbl[i].eren});
      chk("t_imem_addr", imem_addr, tbl[i].eaddr);
      if (tbl[i].ev || tbl[i].rst) begin
        chk("t_out_pc", out_pc, tbl[i].epc);
        chk("t_out_instr", out_instr, tbl[i].einstr);
      end
      @(posedge clk);
      #1;
    end

    // Async reset asserted between edges while the queue holds data.
    cur = 1000;
    out_ready = 1'b0; redirect_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", {31'h0, out_valid}, 32'h0);
    chk("ar_imem_ren", {31'h0, imem_ren}, 32'h0);
    chk("ar_imem_addr", imem_addr, 32'h0);
    chk("ar_out_pc", out_pc, 32'h0);
    chk("ar_out_instr", out_instr, 32'h0);
    chk("ar2_imem_addr", imem_addr2, 32'h0000_0200);
    chk("ar2_out_valid", {31'h0, out_valid2}, 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("ar2_first_addr", imem_addr2, 32'h0000_0200);
    chk("ar2_first_ren", {31'h0, imem_ren2}, 32'h1);

    // Randomized traffic against the reference model.
    m_pc = 32'h0;
    mq.delete();
    for (int i = 0; i < 400; i++) begin
      logic        rv;
      logic        rdy;
      logic [31:0] rpc;
      logic        ev;
      logic        pop;
      logic        eren;
      cur = 2000 + i;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      apply(1'b0, rv, rpc, rdy);
      ev   = (mq.size() != 0);
      pop  = ev && rdy;
      eren = ((mq.size() < DEPTH) || pop) && !rv;
      chk("r_out_valid", {31'h0, out_valid}, {31'h0, ev});
      chk("r_imem_ren", {31'h0, imem_ren}, {31'h0, eren});
      chk("r_imem_addr", imem_addr, m_pc);
      if (ev) begin
        chk("r_out_pc", out_pc, mq[0][63:32]);
        chk("r_out_instr", out_instr, mq[0][31:0]);
      end
      @(posedge clk);
      #1;
      if (pop) begin
        void'(mq.pop_front());
      end
      if (rv) begin
        mq.delete();
        m_pc = rpc & 32'hFFFF_FFFC;
      end else if (eren) begin
        mq.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      if (i == 0) begin
        chk("ar2_out_valid_after", {31'h0, out_valid2}, 32'h1);
        chk("ar2_out_pc_after", out_pc2, 32'h0000_0200);
        chk("ar2_out_instr_after", out_instr2, 32'h1000_0080);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end. Owns the program counter and drives the combinational-read instruction memory (word-indexed by addr[31:2], data valid the same cycle).
- Captures each fetched {pc, instr} pair into a small FIFO fetch queue.
- Presents the queue head to decode through a valid/ready handshake.
- Accepts redirects from execute (branch/jump) and flushes wrong-path entries.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FQ_DEPTH, 2, fetch-queue entries; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  fetch address to instruction memory; equals pc.
- imem_ren  out  1  fetch enable; high when a fetch is performed this cycle.
- imem_rdata  in  32  instruction word, combinationally valid in the same cycle.
- redirect_valid  in  1  redirect request from execute.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced to 0).
- out_valid  out  1  queue head is valid.
- out_pc  out  32  PC of head instruction.
- out_instr  out  32  head instruction word.
- out_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC; queue empty (rd_ptr = wr_ptr = count = 0).
  - out_valid = 0; out_pc and out_instr = 0; imem_ren = 0 while rst is high.
- pop = out_valid & out_ready.
- can_push = (count < FQ_DEPTH) | pop. A full queue may push in the same cycle it pops.
- Fetch condition is fetch = can_push & ~redirect_valid & ~rst. imem_ren = fetch.
- imem_addr = pc at all times.
- Normal cycle, fetch=1:
  - Write {pc, imem_rdata} at wr_ptr.
  - wr_ptr++ (mod FQ_DEPTH); pc <= pc + 4.
- Stall, fetch=0 and no redirect: pc holds; no write.
- Pointer wrap: rd_ptr and wr_ptr wrap modulo FQ_DEPTH.
- count update: +1 on push only, -1 on pop only, unchanged on push and pop together.
- pc arithmetic: 32-bit wrap-around; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Redirect (redirect_valid=1):
  - pc <= {redirect_pc[31:2], 2'b00}.
  - Queue flushed: count <= 0, rd_ptr <= wr_ptr.
  - No push that cycle.
  - A pop in the same cycle is still a legal handshake, because decode consumed the head; the flush then removes everything else.
  - The first instruction from the target is fetched next cycle and is visible on out_* the cycle after.
- Latency:
  - Instruction fetched in cycle N is on out_* in cycle N+1 when the queue was empty.
  - Redirect-to-out_valid latency is 2 cycles.
  - First out_valid after reset release is 1 cycle after the first fetch.
- Output rules:
  - out_* driven from the entry at rd_ptr; out_valid = (count != 0).
  - out_pc and out_instr hold stable while out_valid & ~out_ready.
- Full queue with out_ready=0: imem_ren=0, pc holds, no entry overwritten.
- Reset mid-operation: immediate return to the reset state regardless of queue contents or pending redirect.

Decomposition:
- Shared package (riscv_pkg):
  - XLEN = 32; INSTR_W = 32.
  - RESET_PC_DEFAULT.
  - fetch_entry_t struct {logic[31:0] pc; logic[31:0] instr;}.
- One natural sub-module: fetch_queue.
  - Synchronous-write FIFO of fetch_entry_t, depth FQ_DEPTH.
  - Ports: push, pop, flush, head, count/full/empty.
- fetch_unit contains the pc register, fetch/redirect control, and one fetch_queue instance.

Test Plan:
- Reset, then free-run with out_ready=1 and memory word i = 32'h1000_0000+i -> imem_addr 0,4,8,…; out_pc 0,4,8 with out_instr 32'h1000_0000, 32'h1000_0001, 32'h1000_0002 on consecutive cycles; first out_valid 1 cycle after first imem_ren.
- Backpressure: out_ready=0 for 5 cycles after reset -> queue fills with pc 0 and 4; imem_ren=0; pc holds at 8; out_pc stays 0; raising out_ready streams 0, 4, 8 with no gaps or duplicates.
- Full with simultaneous pop: queue full, out_ready=1 -> same-cycle push of pc 8 and pop of pc 0; count stays 2.
- Redirect: redirect_valid=1 with redirect_pc=32'h0000_0103 while queue holds 2 entries -> out_valid=0 next cycle; imem_addr=32'h0000_0100; out_pc=32'h100 two cycles after redirect; no stale PCs emitted.
- Redirect while full and stalled, plus pop in the same cycle -> head consumed once, remaining entry discarded, fetch resumes at the target.
- Async reset asserted mid-stream between clock edges -> out_valid=0 and imem_ren=0 immediately; after release, fetch restarts at RESET_PC (parameter override 32'h0000_0200 checked).
